// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   mult_state_t  - 2-bit FSM encoding {IDLE, CALC, DONE}
//   result_neg()  - sign of a 2W product from the mode bit and operand MSBs
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_W_DEFAULT = 32;

  // The magnitude product is negated only for signed operations whose
  // operands have differing signs.
  function automatic logic result_neg(input logic is_signed,
                                      input logic a_msb,
                                      input logic b_msb);
    return is_signed & (a_msb ^ b_msb);
  endfunction

endpackage

// File: rtl/mult_abs.sv
// Combinational WIDTH-bit conditional negate (operand magnitude).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
//
// Ports:
//   val        WIDTH-bit operand
//   is_signed  treat val as two's complement
//   mag        |val| when is_signed, else val unchanged
// The most-negative value maps to 2^(WIDTH-1), which is still representable
// as an unsigned WIDTH-bit number, so no overflow handling is needed.
module mult_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             is_signed,
  output logic [WIDTH-1:0] mag
);

  assign mag = (is_signed && val[WIDTH-1]) ? (-val) : val;

endmodule

// File: rtl/multiply_param.sv
// Parametrised iterative shift-add multiplier (MUL/MULU engine), 2*WIDTH product.
// Latency: WIDTH+1 edges from begin sampled to mult_end (early-terminate build: shorter).
// Backpressure: level handshake; result held in DONE until mult_begin drops.
//
// Ports:
//   clk, resetn            clock (rising edge), async active-low reset
//   mult_begin             level request, held until mult_end; drop in CALC aborts
//   mult_signed            1 = two's-complement operands
//   mult_op1, mult_op2     multiplicand, multiplier
//   product                registered result, only written on CALC->DONE
//   mult_end, mult_busy    DONE / CALC state flags
// Optional feature: define MULT_EARLY_TERM_EN to leave CALC as soon as the
// remaining multiplier bits are all zero.
module multiply_param
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mult_begin,
  input  logic               mult_signed,
  input  logic [WIDTH-1:0]   mult_op1,
  input  logic [WIDTH-1:0]   mult_op2,
  output logic [2*WIDTH-1:0] product,
  output logic               mult_end,
  output logic               mult_busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mult_state_t        state_r, state_nxt;
  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] product_r;
  logic [WIDTH-1:0]   mplr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               neg_r;

  logic [WIDTH-1:0]   op1_mag;
  logic [WIDTH-1:0]   op2_mag;
  logic               calc_last;
  logic               load_en;
  logic               step_en;
  logic               done_en;

  mult_abs #(.WIDTH(WIDTH)) u_abs_op1 (
    .val       (mult_op1),
    .is_signed (mult_signed),
    .mag       (op1_mag)
  );

  mult_abs #(.WIDTH(WIDTH)) u_abs_op2 (
    .val       (mult_op2),
    .is_signed (mult_signed),
    .mag       (op2_mag)
  );

  // The edge that sees calc_last moves to DONE without a further step, so the
  // fixed build spends WIDTH step edges plus one finishing edge in CALC.
`ifdef MULT_EARLY_TERM_EN
  // cnt_r != 0 keeps at least one step edge, so op2 = 0 still takes two edges.
  assign calc_last = (cnt_r == CNT_W'(WIDTH)) ||
                     ((mplr_r == '0) && (cnt_r != '0));
`else
  assign calc_last = (cnt_r == CNT_W'(WIDTH));
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    load_en   = 1'b0;
    step_en   = 1'b0;
    done_en   = 1'b0;
    case (state_r)
      IDLE: begin
        if (mult_begin) begin
          state_nxt = CALC;
          load_en   = 1'b1;
        end
      end
      CALC: begin
        // Dropping the request aborts; product is left untouched.
        if (!mult_begin) begin
          state_nxt = IDLE;
        end else if (calc_last) begin
          state_nxt = DONE;
          done_en   = 1'b1;
        end else begin
          step_en   = 1'b1;
        end
      end
      DONE: begin
        if (!mult_begin) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_r   <= '0;
      acc_r     <= '0;
      product_r <= '0;
      mplr_r    <= '0;
      cnt_r     <= '0;
      neg_r     <= 1'b0;
    end else begin
      if (load_en) begin
        mcand_r <= {{WIDTH{1'b0}}, op1_mag};
        mplr_r  <= op2_mag;
        acc_r   <= '0;
        cnt_r   <= '0;
        neg_r   <= result_neg(mult_signed, mult_op1[WIDTH-1], mult_op2[WIDTH-1]);
      end
      if (step_en) begin
        if (mplr_r[0]) begin
          acc_r <= acc_r + mcand_r;
        end
        mcand_r <= mcand_r << 1;
        mplr_r  <= mplr_r >> 1;
        cnt_r   <= cnt_r + CNT_W'(1);
      end
      if (done_en) begin
        product_r <= neg_r ? (-acc_r) : acc_r;
      end
    end
  end

  assign product   = product_r;
  assign mult_end  = (state_r == DONE);
  assign mult_busy = (state_r == CALC);

endmodule

// File: tb/tb_multiply_param.sv
// Directed bench for multiply_param (WIDTH=32) with a queue scoreboard.
// Stimulus pushes expected product/latency; a negedge monitor pops on each
// rising mult_end and compares product and edge count.
module tb_multiply_param;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn;
  logic           mult_begin;
  logic           mult_signed;
  logic [W-1:0]   mult_op1;
  logic [W-1:0]   mult_op2;
  logic [2*W-1:0] product;
  logic           mult_end;
  logic           mult_busy;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2*W-1:0] p;
    int             lat;
    int             start;
  } exp_t;

  exp_t           sb[$];
  exp_t           mon_e;
  logic           end_q  = 1'b0;
  logic [2*W-1:0] last_p = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiply_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mult_begin  (mult_begin),
    .mult_signed (mult_signed),
    .mult_op1    (mult_op1),
    .mult_op2    (mult_op2),
    .product     (product),
    .mult_end    (mult_end),
    .mult_busy   (mult_busy)
  );

  task automatic check64(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: after edge k (edge 0 samples begin) cyc = start + 1 + k.
  always @(negedge clk) begin
    if (mult_end && !end_q) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_end: mult_end=1 with no operation pending, expected 0");
      end else begin
        mon_e = sb.pop_front();
        check64("product", product, mon_e.p);
        check_int("latency", cyc - mon_e.start - 1, mon_e.lat);
      end
    end
    end_q = mult_end;
  end

  task automatic run_op(input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] p,
                        input int lat_et);
    exp_t e;
    int   k;
    @(negedge clk);
    mult_signed = sgn;
    mult_op1    = a;
    mult_op2    = b;
    mult_begin  = 1'b1;
    e.p     = p;
`ifdef MULT_EARLY_TERM_EN
    e.lat   = lat_et;
`else
    e.lat   = W + 1;
`endif
    e.start = cyc;
    sb.push_back(e);
    k = 0;
    while (!mult_end && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!mult_end) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: mult_end=0 after %0d cycles, expected 1", k);
      sb.delete();
    end else begin
      last_p = p;
    end
    mult_begin = 1'b0;
    @(negedge clk);
    check_int("end_drop", int'(mult_end), 0);
    check64("product_hold", product, last_p);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    mult_begin  = 1'b0;
    mult_signed = 1'b0;
    mult_op1    = '0;
    mult_op2    = '0;
    repeat (2) @(negedge clk);
    check64("reset_product", product, 64'h0);
    check_int("reset_end", int'(mult_end), 0);
    check_int("reset_busy", int'(mult_busy), 0);
    resetn = 1'b1;

    // sign, op1, op2, product, early-terminate latency
    run_op(1'b0, 32'h0000_1111, 32'h0000_1111, 64'h0000_0000_0123_4321, 14);
    run_op(1'b0, 32'h0000_1111, 32'h0000_2222, 64'h0000_0000_0246_8642, 15);
    run_op(1'b0, 32'h0000_0002, 32'hFFFF_FFFF, 64'h0000_0001_FFFF_FFFE, 33);
    run_op(1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    run_op(1'b1, 32'h0000_0002, 32'hFFFF_DB77, 64'hFFFF_FFFF_FFFF_B6EE, 15);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 2);
    run_op(1'b0, 32'h0000_0007, 32'h0000_0002, 64'h0000_0000_0000_000E, 3);
    run_op(1'b0, 32'h0000_0005, 32'h0000_0000, 64'h0000_0000_0000_0000, 2);
    run_op(1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'h0000_0000_0000_000F, 4);

    // Abort: op2 MSB set keeps CALC running past edge 10 in either build.
    @(negedge clk);
    mult_signed = 1'b0;
    mult_op1    = 32'h0000_0003;
    mult_op2    = 32'h8000_0000;
    mult_begin  = 1'b1;
    @(negedge clk);
    check_int("busy_in_calc", int'(mult_busy), 1);
    repeat (9) @(negedge clk);
    mult_begin = 1'b0;
    @(negedge clk);
    check_int("abort_busy", int'(mult_busy), 0);
    check_int("abort_end", int'(mult_end), 0);
    check64("abort_product", product, last_p);
    repeat (5) @(negedge clk);
    check_int("abort_end_later", int'(mult_end), 0);

    // Reset in the middle of CALC.
    @(negedge clk);
    mult_op1   = 32'h0000_0009;
    mult_op2   = 32'h8000_0001;
    mult_begin = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check64("midreset_product", product, 64'h0);
    check_int("midreset_busy", int'(mult_busy), 0);
    check_int("midreset_end", int'(mult_end), 0);
    mult_begin = 1'b0;
    last_p     = '0;
    @(negedge clk);
    resetn = 1'b1;

    run_op(1'b0, 32'h0000_0007, 32'h0000_0002, 64'h0000_0000_0000_000E, 3);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
